fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the core. It acts as a Wishbone master that reads 64-bit instruction words from the instruction ROM (a Wishbone slave) and buffers them in a small prefetch FIFO. It hands instructions, with their addresses, to decode over a valid/ready handshake. It also handles control-flow redirects and bus error faults.

## Interface
Parameters:
- `RESET_PC`, 0: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch entries; must be a power of 2, ≥2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `fetch_cyc_o`, out, 1: Wishbone cycle.
- `fetch_stb_o`, out, 1: Wishbone strobe.
- `fetch_we_o`, out, 1: tied 0.
- `fetch_adr_o`, out, `ADR_WIDTH`: byte address of the requested word.
- `fetch_dat_o`, out, `DAT_WIDTH`: tied 0.
- `fetch_dat_i`, in, `DAT_WIDTH`: instruction word.
- `fetch_ack_i`, in, 1: transfer complete.
- `fetch_err_i`, in, 1: transfer failed.
- `inst_o`, out, `DAT_WIDTH`: instruction at the FIFO head.
- `inst_pc_o`, out, `ADR_WIDTH`: address of `inst_o`.
- `inst_valid_o`, out, 1: head entry is valid.
- `inst_ready_i`, in, 1: decode accepts the head entry.
- `redirect_i`, in, 1: one-cycle pulse requesting a control-flow change.
- `redirect_pc_i`, in, `ADR_WIDTH`: new fetch address.
- `fault_o`, out, 1: fetch fault is pending.
- `fault_pc_o`, out, `ADR_WIDTH`: address that faulted.

## Operation
The unit has three states: `IDLE`, `BUS`, `GAP`. The fetch address `pc` advances by 8 per word.

- **`IDLE`**
  - Go to `BUS` when the FIFO is not full and no fault is latched.
  - Drive `cyc`/`stb` high with `adr=pc`.
- **`BUS`**
  - Hold `cyc`, `stb` and `adr` stable until `ack_i` or `err_i`.
  - On `ack_i`: push `{dat_i, adr}` into the FIFO, set `pc += 8`, go to `GAP`.
  - On `err_i`: latch the fault with `fault_pc = adr`, push nothing, go to `GAP`.
- **`GAP`**
  - `cyc`/`stb` stay low for exactly one cycle. This is mandatory so the slave returns to idle.
  - Then go to `IDLE`.

Redirect:
- Flushes the FIFO, clears any latched fault, and loads `pc = redirect_pc_i`.
- An in-flight `BUS` transfer is not aborted. It completes normally, but its data or error is discarded (set a `drop` flag).
- Redirect in the same cycle as `ack_i`/`err_i`: the result is discarded and `pc` takes `redirect_pc_i`.
- Redirect in the same cycle as a pop: redirect wins and the FIFO ends up empty.
- The low 3 bits of `redirect_pc_i` are ignored; the address is forced 8-aligned.

Output handshake:
- A pop happens when `inst_valid_o & inst_ready_i`.
- `inst_o` and `inst_pc_o` stay stable while valid and not ready.
- Push and pop in the same cycle are legal when the FIFO is full or empty (count unchanged when full).

Fault reporting:
- `fault_o` asserts only once the fault is latched and the FIFO is empty, so earlier instructions drain first.
- `fault_o` stays high until `redirect_i` or reset.

Address arithmetic:
- `pc` wraps modulo 2^`ADR_WIDTH`.

## Timing
- Reset values: `cyc`/`stb`/`we` = 0, `adr` = `RESET_PC`, `dat_o` = 0, `inst_valid_o` = 0, `inst_o`/`inst_pc_o` = 0, `fault_o` = 0, `fault_pc_o` = 0. State = `IDLE`, FIFO empty.
- A reset asserted mid-transfer drops `stb` in the next cycle.
- `stb` rises on the first cycle after reset deassertion.
- A slave with a registered ack (one wait cycle) gives one word every 3 cycles: `stb`, `ack`, gap.
- Latency from `ack_i` to `inst_valid_o` is 1 cycle (FIFO registered).
- After redirect, the first new `stb` occurs 1 cycle later if idle, or after the pending `GAP` if busy.

## Configuration
Macro `FETCH_PREFETCH_EN`:
- **Defined:** FIFO of `FIFO_DEPTH` entries; fetching continues while the FIFO is not full.
- **Undefined:** a single-entry buffer; the next fetch starts only after the current entry is popped or flushed. `FIFO_DEPTH` is ignored.

## Structure
- State encodings `FETCH_STATE_IDLE/BUS/GAP` and the instruction size constant (8) live in the shared `config.v` header, next to `DAT_WIDTH`/`ADR_WIDTH`.
- The buffer is a sub-module `fetch_fifo`: sync push/pop/flush, count, full/empty flags, width `DAT_WIDTH+ADR_WIDTH`.

## Test plan
- **Reset then fetch:** reset, slave with registered ack returning `0x0288400000100210` at address 0 and `0x0280800000000e60` at 8 → decode sees those words with pc 0 then 8; `stb` low for exactly one cycle between transfers.
- **Backpressure:** `inst_ready_i=0` → fetching stops after 4 pushes (prefetch on) or 1 push (off); `inst_o` stable; resumes after one pop.
- **Redirect during `BUS`:** `redirect_i` with `0x800000000018` while `stb` high → the in-flight word is discarded, the FIFO is empty, and the next `adr` is `0x800000000018`.
- **Redirect coinciding with ack and pop:** all three in one cycle → FIFO empty and next `adr` = the redirect target.
- **Bus error:** slave returns `err_i` at address `0x30` with 2 entries queued → both drain, then `fault_o=1` with `fault_pc_o=0x30`, no further `stb`; a redirect clears the fault.
- **Mid-transfer reset:** `rst_i` while in `BUS` → next cycle `stb`=0, FIFO empty, `adr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, the
// instruction size, the fetch FSM state encoding and the PC alignment helper.
package fetch_unit_pkg;

  localparam int DAT_WIDTH = 64;
  localparam int ADR_WIDTH = 48;

  // Every instruction word is 8 bytes, so the PC steps by 8 and its low
  // three bits are always zero.
  localparam logic [ADR_WIDTH-1:0] INST_BYTES = ADR_WIDTH'(8);

  typedef enum logic [1:0] {
    FETCH_STATE_IDLE = 2'd0,
    FETCH_STATE_BUS  = 2'd1,
    FETCH_STATE_GAP  = 2'd2
  } fetch_state_e;

  // Force an address onto an instruction-word boundary.
  function automatic logic [ADR_WIDTH-1:0] align_pc(input logic [ADR_WIDTH-1:0] adr);
    return {adr[ADR_WIDTH-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the bus side of the fetch stage and decode.
// Synchronous push/pop/flush; flush and reset both empty it. A push into a
// full buffer is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 2 ** PTR_W;

  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so a single-entry buffer keeps both at slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush discards everything queued.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: Wishbone master reading 64-bit words from the
// instruction ROM into a prefetch buffer, handing them to decode over a
// valid/ready handshake, with control-flow redirects and bus fault capture.
//
// Build option FETCH_PREFETCH_EN: when defined the buffer holds FIFO_DEPTH
// entries and fetching runs ahead while there is room; when undefined the
// buffer holds a single entry and the next fetch waits for it to be popped
// or flushed.
//
// The strobe is raised combinationally in IDLE so that, with a slave using a
// registered ack, a word is transferred every three cycles (strobe, ack, gap).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Wishbone master towards the instruction ROM
  output logic                 fetch_cyc_o,
  output logic                 fetch_stb_o,
  output logic                 fetch_we_o,
  output logic [ADR_WIDTH-1:0] fetch_adr_o,
  output logic [DAT_WIDTH-1:0] fetch_dat_o,
  input  logic [DAT_WIDTH-1:0] fetch_dat_i,
  input  logic                 fetch_ack_i,
  input  logic                 fetch_err_i,
  // Instruction stream towards decode
  output logic [DAT_WIDTH-1:0] inst_o,
  output logic [ADR_WIDTH-1:0] inst_pc_o,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  // Control-flow change
  input  logic                 redirect_i,
  input  logic [ADR_WIDTH-1:0] redirect_pc_i,
  // Fetch fault report
  output logic                 fault_o,
  output logic [ADR_WIDTH-1:0] fault_pc_o
);

`ifdef FETCH_PREFETCH_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int ENT_W = DAT_WIDTH + ADR_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: FIFO_DEPTH must be a power of two and at least 2");
  end

  fetch_state_e         state_q;
  fetch_state_e         state_d;
  logic [ADR_WIDTH-1:0] pc_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [ADR_WIDTH-1:0] fault_pc_q;
  logic [ADR_WIDTH-1:0] cur_adr;
  logic                 drop_q;
  logic                 fault_q;
  logic                 start;
  logic                 bus_active;
  logic                 xfer_done;
  logic                 discard;
  logic                 push;
  logic                 pop;
  logic                 fault_set;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENT_W-1:0]     fifo_rdata;

  // Next state and bus request. A transfer starts from IDLE only when there
  // is room, no fault is pending and no redirect is arriving (a redirect in
  // IDLE simply retargets the PC, so the first new strobe follows next cycle).
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    bus_active = 1'b0;
    case (state_q)
      FETCH_STATE_IDLE: begin
        if (!rst_i && !fifo_full && !fault_q && !redirect_i) begin
          start      = 1'b1;
          bus_active = 1'b1;
        end
      end
      FETCH_STATE_BUS: begin
        bus_active = 1'b1;
      end
      FETCH_STATE_GAP: begin
        state_d = FETCH_STATE_IDLE;
      end
      default: begin
        state_d = FETCH_STATE_IDLE;
      end
    endcase
    xfer_done = bus_active & (fetch_ack_i | fetch_err_i);
    if (bus_active) state_d = xfer_done ? FETCH_STATE_GAP : FETCH_STATE_BUS;
  end

  // While a transfer is open the address comes from the captured copy so a
  // redirect that moves the PC cannot disturb the cycle on the bus.
  assign cur_adr = (state_q == FETCH_STATE_IDLE) ? pc_q : adr_q;

  // A completion is thrown away if a redirect arrived earlier in this
  // transfer or arrives in the very cycle the slave answers.
  assign discard   = drop_q | redirect_i;
  assign push      = xfer_done & fetch_ack_i & ~fetch_err_i & ~discard;
  assign fault_set = xfer_done & fetch_err_i & ~discard;
  assign pop       = ~fifo_empty & inst_ready_i;

  // Control state: FSM, fetch PC, drop marker and fault latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_STATE_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q <= align_pc(redirect_pc_i);
      end else if (push) begin
        pc_q <= cur_adr + INST_BYTES;
      end
      if (xfer_done) begin
        drop_q <= 1'b0;
      end else if (redirect_i && bus_active) begin
        drop_q <= 1'b1;
      end
      if (redirect_i) begin
        fault_q <= 1'b0;
      end else if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Captured bus address and faulting address; only read while qualified.
  always_ff @(posedge clk_i) begin
    if (start)     adr_q      <= pc_q;
    if (fault_set) fault_pc_q <= cur_adr;
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({fetch_dat_i, cur_adr}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fetch_cyc_o = bus_active;
  assign fetch_stb_o = bus_active;
  assign fetch_we_o  = 1'b0;
  assign fetch_adr_o = cur_adr;
  assign fetch_dat_o = '0;

  // Head entry is presented only while valid so idle outputs read as zero.
  assign inst_valid_o         = ~fifo_empty;
  assign {inst_o, inst_pc_o}  = fifo_empty ? '0 : fifo_rdata;

  // A fault is reported only after every older instruction has drained.
  assign fault_o    = fault_q & (fifo_count == '0);
  assign fault_pc_o = fault_o ? fault_pc_q : '0;

endmodule
